spot_frame_writer: RTL

Upstream feeder for `main_spot_finder`. Packs the 8-bit camera pixel stream into 256-bit kernels of 32 pixels and writes them linearly into the spot-finder block RAM. Measures the frame geometry as `cam_kernels_x`/`cam_lines_y` and hands each complete frame to the spot finder with a start pulse. Holds that frame until `analysis_rdy` is seen, dropping and counting any frames that arrive meanwhile.

---
 rtl/spot_pkg.sv | 16 +
 rtl/kernel_packer.sv | 41 ++++
 rtl/spot_frame_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spot_pkg.sv
// Shared constants and types for the spot-finder front end (frame writer and spot finder).
package spot_pkg;

  localparam int unsigned PIX_PER_KERNEL = 32;
  localparam int unsigned PIX_W          = 8;
  localparam int unsigned KERNEL_W       = 256;
  localparam int unsigned PIX_IDX_W      = $clog2(PIX_PER_KERNEL);
  localparam int unsigned ROI_W          = 10;

  typedef enum logic [1:0] {
    ARMED,
    CAPTURE,
    LOCKED
  } writer_state_e;

endpackage

// File: rtl/kernel_packer.sv
// Packs 8-bit pixels into a 256-bit kernel; pixel n lands at bits [8n+7:8n].
// word shows the kernel including the pixel being pushed this cycle.
module kernel_packer
  import spot_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 push,
  input  logic                 flush,
  output logic [PIX_IDX_W-1:0] pixel_idx,
  output logic                 word_full,
  output logic [KERNEL_W-1:0]  word
);

  logic [KERNEL_W-1:0] word_q;

  assign word_full = push && (pixel_idx == PIX_IDX_W'(PIX_PER_KERNEL - 1));

  always_comb begin
    word = word_q;
    if (push) begin
      word[{pixel_idx, 3'b000} +: PIX_W] = pix_data;
    end
  end

  // Clearing to zero after every emit gives zero padding for partial kernels for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      pixel_idx <= '0;
    end else if (flush || word_full) begin
      word_q    <= '0;
      pixel_idx <= '0;
    end else if (push) begin
      word_q    <= word;
      pixel_idx <= pixel_idx + PIX_IDX_W'(1);
    end
  end

endmodule

// File: rtl/spot_frame_writer.sv
// Packs the camera stream into kernels, writes them to BRAM and hands frames to the spot finder.
// Build option: SPOT_WRITER_PARTIAL_FLUSH_EN pads and writes the partial kernel at line end.
module spot_frame_writer
  import spot_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W    = 14,
  parameter int unsigned MAX_KERNELS_X = 20,
  parameter int unsigned MAX_LINES_Y   = 480
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_valid,
  input  logic                  line_valid,
  input  logic                  frame_valid,
  input  logic                  analysis_rdy,
  output logic [KERNEL_W-1:0]   mem_data,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic                  mem_we,
  output logic [15:0]           cam_kernels_x,
  output logic [15:0]           cam_lines_y,
  output logic                  frame_start,
  output logic [7:0]            frames_dropped,
  output logic                  geom_err
);

  writer_state_e state_q, state_d;

  logic        fv_low_q, lv_q;
  logic [15:0] kernel_idx_q, line_idx_q, width_q;
  logic        line_has_pix_q, frame_has_pix_q, addr_done_q, start_pend_q;

  logic [PIX_IDX_W-1:0] pixel_idx;
  logic                 word_full;
  logic [KERNEL_W-1:0]  packed_word;

  logic        frame_rise, entering, pix_try, pix_accept, over_x, over_y;
  logic        frame_end, line_end, flush_wr, write_req, write_ok, mismatch;
  logic        lock_frame, start_now, start_later, drop_inc, geom_set;
  logic [15:0] line_kernels, width_new, lines_new;

  kernel_packer u_packer (
    .clk       (clk_in),
    .rst       (reset),
    .pix_data  (pix_data),
    .push      (pix_accept),
    .flush     (line_end),
    .pixel_idx (pixel_idx),
    .word_full (word_full),
    .word      (packed_word)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:   if (frame_rise) state_d = CAPTURE;
      CAPTURE: if (frame_end) state_d = frame_has_pix_q ? LOCKED : ARMED;
      LOCKED:  if (analysis_rdy && !start_pend_q) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  // fv_low_q resets to 0, so a frame already running at reset release never looks like a rise.
  always_comb begin
    frame_rise = frame_valid && fv_low_q;
    entering   = (state_q == ARMED) && frame_rise;
    pix_try    = (state_q == CAPTURE) && frame_valid && line_valid && pix_valid;
    over_x     = kernel_idx_q == 16'(MAX_KERNELS_X);
    over_y     = line_idx_q == 16'(MAX_LINES_Y);
    pix_accept = pix_try && !over_x && !over_y;
    frame_end  = (state_q == CAPTURE) && !frame_valid;
    // A frame ending mid-line closes that line first.
    line_end   = (state_q == CAPTURE) && line_has_pix_q && ((lv_q && !line_valid) || !frame_valid);
`ifdef SPOT_WRITER_PARTIAL_FLUSH_EN
    flush_wr     = line_end && (pixel_idx != '0);
    line_kernels = kernel_idx_q + {15'd0, (pixel_idx != '0)};
`else
    flush_wr     = 1'b0;
    line_kernels = kernel_idx_q;
`endif
    write_req   = word_full || flush_wr;
    write_ok    = write_req && !addr_done_q;
    width_new   = (line_end && (line_idx_q == '0)) ? line_kernels : width_q;
    lines_new   = line_idx_q + {15'd0, line_end};
    mismatch    = line_end && (line_idx_q != '0) && (line_kernels != width_q);
    lock_frame  = frame_end && frame_has_pix_q;
    start_now   = (lock_frame && !flush_wr) || start_pend_q;
    start_later = lock_frame && flush_wr;
    drop_inc    = (state_q == LOCKED) && frame_rise && (frames_dropped != 8'hFF);
    geom_set    = (pix_try && (over_x || over_y)) || mismatch || (write_req && addr_done_q);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      fv_low_q        <= 1'b0;
      lv_q            <= 1'b0;
      mem_we          <= 1'b0;
      mem_data        <= '0;
      mem_address     <= '0;
      addr_done_q     <= 1'b0;
      cam_kernels_x   <= '0;
      cam_lines_y     <= '0;
      frame_start     <= 1'b0;
      start_pend_q    <= 1'b0;
      frames_dropped  <= '0;
      geom_err        <= 1'b0;
      kernel_idx_q    <= '0;
      line_idx_q      <= '0;
      width_q         <= '0;
      line_has_pix_q  <= 1'b0;
      frame_has_pix_q <= 1'b0;
    end else begin
      fv_low_q     <= ~frame_valid;
      lv_q         <= line_valid;
      mem_we       <= write_ok;
      frame_start  <= start_now;
      start_pend_q <= start_later;
      if (write_ok) mem_data <= packed_word;
      if (lock_frame) begin
        cam_kernels_x <= width_new;
        cam_lines_y   <= lines_new;
      end
      if (drop_inc) frames_dropped <= frames_dropped + 8'd1;
      if (geom_set) geom_err <= 1'b1;

      if (entering) begin
        mem_address     <= '0;
        addr_done_q     <= 1'b0;
        kernel_idx_q    <= '0;
        line_idx_q      <= '0;
        width_q         <= '0;
        line_has_pix_q  <= 1'b0;
        frame_has_pix_q <= 1'b0;
      end else begin
        // Address advances the cycle after the write; the top address is written once, never wrapped.
        if (mem_we) begin
          if (mem_address == '1) addr_done_q <= 1'b1;
          else mem_address <= mem_address + MEM_ADDR_W'(1);
        end
        if (line_end) kernel_idx_q <= '0;
        else if (word_full) kernel_idx_q <= kernel_idx_q + 16'd1;
        line_idx_q <= lines_new;
        width_q    <= width_new;
        if (line_end) line_has_pix_q <= 1'b0;
        else if (pix_accept) line_has_pix_q <= 1'b1;
        if (pix_accept) frame_has_pix_q <= 1'b1;
      end
    end
  end

endmodule
